// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear request, busy flag, two write ports and NRD packed read ports.
interface regfile_mp_if #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int NRD     = 2
);
  localparam int AW = $clog2(REG_NUM);

  logic                    clr;
  logic                    init_busy;
  logic                    wen0;
  logic [AW-1:0]           waddr0;
  logic [DATA_W-1:0]       wdata0;
  logic                    wen1;
  logic [AW-1:0]           waddr1;
  logic [DATA_W-1:0]       wdata1;
  logic [NRD*AW-1:0]       raddr;
  logic [NRD*DATA_W-1:0]   rdata;

  modport master (
    output clr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr,
    input  init_busy, rdata
  );

  modport slave (
    input  clr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr,
    output init_busy, rdata
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised writes, optional
// write-to-read bypass and a clear sweep that zeroes every entry after reset or on clr.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int              AW      = $clog2(REG_NUM);
  localparam logic [AW:0]     NUM_W   = (AW+1)'(REG_NUM);
  localparam logic [AW-1:0]   LAST    = AW'(REG_NUM - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                busy;
  logic                we0_ok, we1_ok;
  logic [AW-1:0]       ra_c;
  logic [NRD*DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0]   mem_q [REG_NUM];

  // An address is usable when it exists and is not the hardwired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NUM_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign busy   = (state_q == CLEAR);
  assign we0_ok = bus.wen0 && !busy && addr_ok(bus.waddr0);
  assign we1_ok = bus.wen1 && !busy && addr_ok(bus.waddr1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (bus.clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: the array has no reset; the clear sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0_ok) mem_q[bus.waddr0] <= bus.wdata0;
      // Port 1 is assigned last so it wins a same-address collision.
      if (we1_ok) mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

  always_comb begin
    rdata_c = '0;
    ra_c    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra_c = bus.raddr[k*AW +: AW];
      if (!busy && addr_ok(ra_c)) begin
        if ((BYPASS != 0) && we1_ok && (bus.waddr1 == ra_c)) begin
          rdata_c[k*DATA_W +: DATA_W] = bus.wdata1;
        end else if ((BYPASS != 0) && we0_ok && (bus.waddr0 == ra_c)) begin
          rdata_c[k*DATA_W +: DATA_W] = bus.wdata0;
        end else begin
          rdata_c[k*DATA_W +: DATA_W] = mem_q[ra_c];
        end
      end
    end
  end

  assign bus.rdata     = rdata_c;
  assign bus.init_busy = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two regfile_mp configurations driven in lockstep against a
// behavioural model (arrays plus a busy-cycle countdown).
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NA = 32, RA = 2;   // BYPASS=1, ZERO_REG=1
  localparam int NB = 24, RB = 3;   // BYPASS=0, ZERO_REG=0

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          clr, wen0, wen1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic [AW-1:0] ra_a [RA];
  logic [AW-1:0] ra_b [RB];

  regfile_mp_if #(.DATA_W(DW), .REG_NUM(NA), .NRD(RA)) ifa ();
  regfile_mp_if #(.DATA_W(DW), .REG_NUM(NB), .NRD(RB)) ifb ();

  assign ifa.clr = clr;   assign ifb.clr = clr;
  assign ifa.wen0 = wen0; assign ifb.wen0 = wen0;
  assign ifa.wen1 = wen1; assign ifb.wen1 = wen1;
  assign ifa.waddr0 = wa0; assign ifb.waddr0 = wa0;
  assign ifa.waddr1 = wa1; assign ifb.waddr1 = wa1;
  assign ifa.wdata0 = wd0; assign ifb.wdata0 = wd0;
  assign ifa.wdata1 = wd1; assign ifb.wdata1 = wd1;
  assign ifa.raddr = {ra_a[1], ra_a[0]};
  assign ifb.raddr = {ra_b[2], ra_b[1], ra_b[0]};

  regfile_mp #(.DATA_W(DW), .REG_NUM(NA), .NRD(RA), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  regfile_mp #(.DATA_W(DW), .REG_NUM(NB), .NRD(RB), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  // Reference model: stored contents and remaining busy cycles per instance.
  logic [DW-1:0] ma [NA];
  logic [DW-1:0] mb [NB];
  int busy_a, busy_b;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int n, input bit byp, input bit zr,
                                           input int busy, input logic [AW-1:0] a,
                                           input logic [DW-1:0] stored);
    if (busy > 0 || int'(a) >= n || (zr && a == 0)) return '0;
    if (byp && wen1 && wa1 == a) return wd1;
    if (byp && wen0 && wa0 == a) return wd0;
    return stored;
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] st;
    check("busy_a", {31'b0, ifa.init_busy}, {31'b0, busy_a > 0});
    check("busy_b", {31'b0, ifb.init_busy}, {31'b0, busy_b > 0});
    for (int k = 0; k < RA; k++) begin
      st = ma[ra_a[k]];
      check($sformatf("rd_a%0d[%0d]", k, ra_a[k]), ifa.rdata[k*DW +: DW],
            exp_rd(NA, 1'b1, 1'b1, busy_a, ra_a[k], st));
    end
    for (int k = 0; k < RB; k++) begin
      st = (int'(ra_b[k]) < NB) ? mb[ra_b[k]] : '0;
      check($sformatf("rd_b%0d[%0d]", k, ra_b[k]), ifb.rdata[k*DW +: DW],
            exp_rd(NB, 1'b0, 1'b0, busy_b, ra_b[k], st));
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      busy_a = NA;
      busy_b = NB;
      return;
    end
    if (busy_a > 0) begin
      if (clr) busy_a = NA;
      else begin
        busy_a--;
        if (busy_a == 0) foreach (ma[i]) ma[i] = '0;
      end
    end else begin
      if (wen0 && wa0 != 0) ma[wa0] = wd0;
      if (wen1 && wa1 != 0) ma[wa1] = wd1;
      if (clr) busy_a = NA;
    end
    if (busy_b > 0) begin
      if (clr) busy_b = NB;
      else begin
        busy_b--;
        if (busy_b == 0) foreach (mb[i]) mb[i] = '0;
      end
    end else begin
      if (wen0 && int'(wa0) < NB) mb[wa0] = wd0;
      if (wen1 && int'(wa1) < NB) mb[wa1] = wd1;
      if (clr) busy_b = NB;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    clr = 0; wen0 = 0; wen1 = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic run_until_ready();
    for (int i = 0; i < 40 && (busy_a > 0 || busy_b > 0); i++) begin
      if (i == 3) begin
        wen0 = 1; wa0 = 5'd3; wd0 = 32'h55;
      end else begin
        wen0 = 0;
      end
      ra_a[0] = 5'd3; ra_b[0] = 5'd3;
      step();
    end
    wen0 = 0;
  endtask

  task automatic read_sweep();
    idle();
    for (int i = 0; i < 32; i++) begin
      ra_a[0] = AW'(i);
      ra_a[1] = AW'(31 - i);
      for (int k = 0; k < RB; k++) ra_b[k] = AW'((i + k * 7) % 32);
      step();
    end
  endtask

  task automatic fill_index();
    idle();
    for (int i = 1; i < 32; i += 2) begin
      wen0 = 1; wa0 = AW'(i);     wd0 = DW'(i);
      wen1 = (i + 1 < 32);        wa1 = AW'(i + 1); wd1 = DW'(i + 1);
      step();
    end
    idle();
  endtask

  task automatic do_async_reset();
    rst = 0;
    busy_a = NA;
    busy_b = NB;
    step();
    rst = 1;
  endtask

  initial begin
    idle();
    foreach (ra_a[k]) ra_a[k] = '0;
    foreach (ra_b[k]) ra_b[k] = '0;
    rst = 0;
    busy_a = NA;
    busy_b = NB;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    rst = 1;
    run_until_ready();
    read_sweep();

    // Same-address collision: port 1 wins.
    wen0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    wen1 = 1; wa1 = 5'd5; wd1 = 32'h12345678;
    step();
    idle(); ra_a[0] = 5'd5; ra_b[0] = 5'd5;
    #1 check("t2_collide_a", ifa.rdata[0 +: DW], 32'h12345678);
    check("t2_collide_b", ifb.rdata[0 +: DW], 32'h12345678);
    step();

    // Bypass on A, old value on B.
    wen0 = 1; wa0 = 5'd7; wd0 = 32'hA5A5A5A5;
    ra_a[0] = 5'd7; ra_b[0] = 5'd7;
    #1 check("t3_bypass_a", ifa.rdata[0 +: DW], 32'hA5A5A5A5);
    check("t3_nobypass_b", ifb.rdata[0 +: DW], 32'h0);
    step();
    idle();
    step();

    // Entry 0 hardwired on A only.
    wen1 = 1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra_a[0] = 5'd0; ra_b[0] = 5'd0;
    #1 check("t4_zero_a", ifa.rdata[0 +: DW], 32'h0);
    step();
    idle();
    #1 check("t4_zero_a_after", ifa.rdata[0 +: DW], 32'h0);
    check("t4_entry0_b", ifb.rdata[0 +: DW], 32'hFFFFFFFF);
    step();

    // Clear request with a dropped write during the sweep.
    fill_index();
    read_sweep();
    clr = 1;
    step();
    clr = 0;
    run_until_ready();
    read_sweep();

    // Reset mid-sweep at counter 10 restarts the sweep.
    fill_index();
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 10; i++) step();
    do_async_reset();
    run_until_ready();
    read_sweep();

    // Out-of-range address on the 24-entry instance.
    wen0 = 1; wa0 = 5'd30; wd0 = 32'hCAFEF00D;
    foreach (ra_b[k]) ra_b[k] = 5'd30;
    ra_a[0] = 5'd30;
    step();
    idle();
    foreach (ra_b[k]) ra_b[k] = 5'd30;
    #1 check("t6_oor_b0", ifb.rdata[0 +: DW], 32'h0);
    check("t6_oor_b2", ifb.rdata[2*DW +: DW], 32'h0);
    check("t6_inrange_a", ifa.rdata[0 +: DW], 32'hCAFEF00D);
    step();
    read_sweep();

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 49) == 0);
      wen0 = $urandom_range(0, 1) != 0;
      wen1 = $urandom_range(0, 1) != 0;
      wa0  = AW'($urandom_range(0, 31));
      wa1  = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 31));
      wd0  = $urandom;
      wd1  = $urandom;
      for (int k = 0; k < RA; k++)
        ra_a[k] = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom_range(0, 31));
      for (int k = 0; k < RB; k++)
        ra_b[k] = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom_range(0, 31));
      step();
    end
    idle();
    run_until_ready();
    read_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
